// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control/config inputs and registered decode outputs.
// master drives the controls, slave is the decoder itself.
interface scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               en_i;
  logic               mode_i;
  logic [SEL_W-1:0]   sel_i;
  logic [SEL_W-1:0]   scan_last_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [OUT_W-1:0]   out_o;
  logic [SEL_W-1:0]   idx_o;
  logic               wrap_o;

  modport master (
    output en_i, mode_i, sel_i, scan_last_i, dwell_i,
    input  out_o, idx_o, wrap_o
  );

  modport slave (
    input  en_i, mode_i, sel_i, scan_last_i, dwell_i,
    output out_o, idx_o, wrap_o
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct select or auto-scan over 0..scan_last, dwell+1 cycles per step.
// All outputs are registered: one clk edge from inputs to out/idx/wrap; no backpressure.
module scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  scan_decoder_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               wrap_q, wrap_d;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    out_d  = '0;
    wrap_d = 1'b0;
    if (bus.en_i) begin
      if (!bus.mode_i) begin
        idx_d = bus.sel_i;
        cnt_d = '0;
      end else if (cnt_q < bus.dwell_i) begin
        cnt_d = cnt_q + DWELL_W'(1);
      end else begin
        cnt_d = '0;
        // Explicit wrap so a lowered scan_last or a full-range scan never counts past the limit.
        if (idx_q >= bus.scan_last_i) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      out_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out_o  = out_q;
  assign bus.idx_o  = idx_q;
  assign bus.wrap_o = wrap_q;
endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered binary-to-one-hot decoder with enable and a built-in auto-scan sequencer. It generalises the lab 2-to-4 enabled decoder to 2^SEL_W outputs. In direct mode it decodes an external select. In scan mode it walks the active output through a programmable range with a programmable dwell per step. Typical uses are multiplexed display digit strobes, keypad column drive and round-robin channel enables.

## Interface
- SEL_W, 3, select/index width; output width is 2**SEL_W
- DWELL_W, 8, width of the dwell count
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  enable; when low, all outputs go inactive and the scan holds
- mode  input  1  0 = direct decode of sel, 1 = auto-scan
- sel  input  SEL_W  direct-mode select
- scan_last  input  SEL_W  highest index visited in scan mode (scan range 0..scan_last)
- dwell  input  DWELL_W  extra cycles per scan step; each step lasts dwell+1 cycles
- out  output  2**SEL_W  registered one-hot decode; all zero when disabled
- idx  output  SEL_W  registered index currently decoded
- wrap  output  1  one-cycle pulse when the scan index returns from its last value to 0

## Operation
- Internal state: idx register, dwell counter cnt (DWELL_W bits), out register, wrap register. There is no other state.
- Reset (asynchronous, any time, including mid-scan): out=0, idx=0, cnt=0, wrap=0. Outputs change immediately on rst rising, not at the next edge. Operation resumes at the first clk edge after rst falls.
- en=0 (either mode): at the next edge out<=0 and wrap<=0. idx and cnt hold their values.
- Direct (en=1, mode=0): at each edge idx<=sel, out<=onehot(sel), cnt<=0, wrap<=0. sel is decoded fully; scan_last is ignored.
- Scan (en=1, mode=1), evaluated at each edge:
  - If cnt<dwell: cnt<=cnt+1, idx holds, wrap<=0.
  - Otherwise (cnt>=dwell): cnt<=0, and the step advances:
    - If idx>=scan_last: idx<=0 and wrap<=1.
    - Else: idx<=idx+1 and wrap<=0.
  - out<=onehot(next idx) every cycle. out and idx always agree in the same cycle.
- Boundary conditions:
  - dwell=0: idx advances every cycle.
  - scan_last=0: idx stays at 0, and wrap pulses once every dwell+1 cycles.
  - scan_last lowered below the current idx: the next advance wraps to 0 with wrap=1. The index never counts up past scan_last.
  - dwell lowered below the current cnt: the cnt>=dwell test fires at the next edge, so the step advances.
  - Direct to scan switch: the scan starts at the current idx (the last sel) with cnt=0.
  - Scan to direct switch: idx<=sel at the same edge.
  - en deasserted then reasserted in scan mode: the scan resumes from the held idx and cnt. No step is lost or repeated.
  - When SEL_W selects exactly 2**SEL_W outputs and scan_last=2**SEL_W-1, the wrap from the maximum to 0 is explicit. It must not rely on natural overflow.
- All arithmetic is unsigned. cnt never exceeds max(dwell, previous cnt).

## Timing
- Latency: out/idx reflect en/mode/sel one clk edge after sampling. The path is registered only; there is no combinational path from input to output.
- Scan step period is dwell+1 cycles. Full scan period is (scan_last+1)*(dwell+1) cycles.
- wrap is high for exactly one cycle, in the same cycle that idx first reads 0 of the new pass. Its spacing equals the full scan period.
- out is one-hot or all-zero in every cycle. It is never multi-hot, including during mode switches.

## Test plan
- Reset: assert rst with no clk edge → out=0, idx=0, wrap=0 immediately. Release rst and hold en=0 for 3 cycles → all outputs stay 0.
- Direct: en=1, mode=0, sel=5 (SEL_W=3) → after 1 edge, out=8'b0010_0000 and idx=5. Set sel=7 → out=8'b1000_0000 on the next edge.
- Scan: mode=1, dwell=2, scan_last=3, starting from idx=0 → idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap=1 only on the first cycle of the final 0, then again every 12 cycles.
- Fast scan and full range: dwell=0, scan_last=7 → idx 0..7,0 on consecutive cycles. wrap pulses every 8 cycles. out is always one-hot.
- Pause and limit change: mid-scan at idx=2 with cnt=1, drop en for 4 cycles → out=0 and idx holds 2; re-enable and the step finishes after the remaining dwell. Then set scan_last=1 while idx=2 → next advance gives idx=0 with wrap=1.
- Asynchronous reset mid-scan: pulse rst between clock edges at idx=3 → out=0 and idx=0 at once. After release, the scan restarts at 0 with a full dwell.
